// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcodes and instruction field positions.
package cpu_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned INST_W = 32;

  localparam logic [5:0] OP_JUMP = 6'h12;
  localparam logic [5:0] OP_BEQ  = 6'h0F;
  localparam logic [5:0] OP_BNE  = 6'h10;

  localparam int unsigned OPC_HI  = 31;
  localparam int unsigned OPC_LO  = 26;
  localparam int unsigned IMM_HI  = 25;
  localparam int unsigned IMM_LO  = 10;
  localparam int unsigned RS_HI   = 9;
  localparam int unsigned RS_LO   = 5;
  localparam int unsigned RD_HI   = 4;
  localparam int unsigned RD_LO   = 0;
  // Jump target lives in the low bits of the 26-bit field below the opcode.
  localparam int unsigned JTGT_HI = 25;

  function automatic logic is_jump(input logic [31:0] inst);
    return inst[OPC_HI:OPC_LO] == OP_JUMP;
  endfunction

endpackage

// File: rtl/inst_fetch_stage_if.sv
// Fetch-stage bus: ROM address/data, downstream stall/redirect, and the IF/ID register outputs.
interface inst_fetch_stage_if #(
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W,
  parameter int unsigned INST_W = cpu_pkg::INST_W,
  parameter int unsigned CNT_W  = 16
);

  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic [ADDR_W-1:0] rom_addr;
  logic [INST_W-1:0] rom_inst;
  logic              if_valid;
  logic [INST_W-1:0] if_inst;
  logic [ADDR_W-1:0] if_pc;
  logic [ADDR_W-1:0] if_pc_plus1;
  logic [CNT_W-1:0]  fetch_cnt;

  modport master (
    input  stall, redirect_valid, redirect_pc, rom_inst,
    output rom_addr, if_valid, if_inst, if_pc, if_pc_plus1, fetch_cnt
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, rom_inst,
    input  rom_addr, if_valid, if_inst, if_pc, if_pc_plus1, fetch_cnt
  );

endinterface

// File: rtl/inst_fetch_stage_npc_sel.sv
// Next-PC selection: redirect target, else local jump target, else sequential pc+1.
module npc_sel #(
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W,
  parameter int unsigned INST_W = cpu_pkg::INST_W
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [INST_W-1:0] rom_inst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] npc
);

  logic              jump;
  logic [ADDR_W-1:0] jump_tgt;

  assign jump     = cpu_pkg::is_jump(rom_inst);
  assign jump_tgt = ADDR_W'(rom_inst[cpu_pkg::JTGT_HI:0]);

  always_comb begin
    npc = pc + 1'b1;
    if (redirect_valid) begin
      npc = redirect_pc;
    end else if (jump) begin
      npc = jump_tgt;
    end
  end

endmodule

// File: rtl/inst_fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the ROM address and fills the IF/ID register.
module inst_fetch_stage #(
  parameter int unsigned       ADDR_W   = cpu_pkg::ADDR_W,
  parameter int unsigned       INST_W   = cpu_pkg::INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       CNT_W    = 16
) (
  input logic                clk,
  input logic                rst,
  inst_fetch_stage_if.master bus
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] npc;
  logic              if_valid;
  logic [INST_W-1:0] if_inst;
  logic [ADDR_W-1:0] if_pc;
  logic [CNT_W-1:0]  fetch_cnt;

  npc_sel #(
    .ADDR_W(ADDR_W),
    .INST_W(INST_W)
  ) u_npc_sel (
    .pc             (pc),
    .rom_inst       (bus.rom_inst),
    .redirect_valid (bus.redirect_valid),
    .redirect_pc    (bus.redirect_pc),
    .npc            (npc)
  );

  // Redirect outranks stall; it only flushes the valid bit, leaving the rest of IF/ID as-is.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      if_valid  <= 1'b0;
      if_inst   <= '0;
      if_pc     <= '0;
      fetch_cnt <= '0;
    end else if (bus.redirect_valid) begin
      pc       <= npc;
      if_valid <= 1'b0;
    end else if (!bus.stall) begin
      pc        <= npc;
      if_valid  <= 1'b1;
      if_inst   <= bus.rom_inst;
      if_pc     <= pc;
      fetch_cnt <= fetch_cnt + 1'b1;
    end
  end

  assign bus.rom_addr    = pc;
  assign bus.if_valid    = if_valid;
  assign bus.if_inst     = if_inst;
  assign bus.if_pc       = if_pc;
  assign bus.if_pc_plus1 = if_pc + 1'b1;
  assign bus.fetch_cnt   = fetch_cnt;

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Directed bench for inst_fetch_stage with a behavioural zero-latency ROM.
module tb_inst_fetch_stage;

  logic clk = 1'b0;
  logic rst;

  int unsigned errors = 0;
  int unsigned checks = 0;

  inst_fetch_stage_if #(.ADDR_W(6), .INST_W(32), .CNT_W(16)) bus ();

  inst_fetch_stage #(
    .ADDR_W   (6),
    .INST_W   (32),
    .RESET_PC (6'h00),
    .CNT_W    (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Standard program: jump at 07 to 0B, nop at 3F, otherwise opcode 01 tagged with its address.
  function automatic logic [31:0] rom_word(input logic [5:0] a);
    case (a)
      6'h01:   return 32'h00101464;
      6'h07:   return 32'h4800000b;
      6'h08:   return 32'h27fffc2a;
      6'h3F:   return 32'h00000000;
      default: return {6'h01, 20'h00000, a};
    endcase
  endfunction

  assign bus.rom_inst = rom_word(bus.rom_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".rom_addr"},    32'(bus.rom_addr),    32'h00);
    check({tag, ".if_valid"},    32'(bus.if_valid),    32'h0);
    check({tag, ".if_inst"},     bus.if_inst,          32'h0);
    check({tag, ".if_pc"},       32'(bus.if_pc),       32'h00);
    check({tag, ".if_pc_plus1"}, 32'(bus.if_pc_plus1), 32'h01);
    check({tag, ".fetch_cnt"},   32'(bus.fetch_cnt),   32'h0000);
  endtask

  initial begin
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 6'h00;
    step();
    step();
    check_reset("reset");
    rst = 1'b0;

    for (int i = 1; i <= 7; i++) begin
      step();
      check($sformatf("seq.rom_addr%0d", i), 32'(bus.rom_addr), 32'(i));
      if (i == 2) begin
        check("seq.if_inst01", bus.if_inst, 32'h00101464);
        check("seq.if_pc01", 32'(bus.if_pc), 32'h01);
      end
    end

    // Jump at 07 lands on 0B with no bubble
    step();
    check("jump.rom_addr", 32'(bus.rom_addr), 32'h0B);
    check("jump.if_inst", bus.if_inst, 32'h4800000b);
    check("jump.if_valid", 32'(bus.if_valid), 32'h1);
    check("jump.if_pc", 32'(bus.if_pc), 32'h07);
    check("jump.fetch_cnt", 32'(bus.fetch_cnt), 32'd8);

    step();
    check("pre_redir.rom_addr", 32'(bus.rom_addr), 32'h0C);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 6'h08;
    step();
    bus.redirect_valid = 1'b0;
    check("redir.rom_addr", 32'(bus.rom_addr), 32'h08);
    check("redir.if_valid", 32'(bus.if_valid), 32'h0);
    check("redir.fetch_cnt", 32'(bus.fetch_cnt), 32'd9);
    step();
    check("redir.if_inst", bus.if_inst, 32'h27fffc2a);
    check("redir.if_pc", 32'(bus.if_pc), 32'h08);
    check("redir.if_valid1", 32'(bus.if_valid), 32'h1);
    check("redir.rom_addr1", 32'(bus.rom_addr), 32'h09);

    // Stall at rom_addr 04
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 6'h03;
    step();
    bus.redirect_valid = 1'b0;
    step();
    check("stall.pre_addr", 32'(bus.rom_addr), 32'h04);
    check("stall.pre_cnt", 32'(bus.fetch_cnt), 32'd11);
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("stall%0d.rom_addr", k), 32'(bus.rom_addr), 32'h04);
      check($sformatf("stall%0d.if_inst", k), bus.if_inst, 32'h04000003);
      check($sformatf("stall%0d.if_pc", k), 32'(bus.if_pc), 32'h03);
      check($sformatf("stall%0d.fetch_cnt", k), 32'(bus.fetch_cnt), 32'd11);
    end
    bus.stall = 1'b0;
    step();
    check("unstall.rom_addr", 32'(bus.rom_addr), 32'h05);
    check("unstall.if_inst", bus.if_inst, 32'h04000004);
    check("unstall.fetch_cnt", 32'(bus.fetch_cnt), 32'd12);

    // Stall + redirect together while the jump at 07 is on rom_inst
    step();
    step();
    check("sr.pre_addr", 32'(bus.rom_addr), 32'h07);
    bus.stall = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 6'h02;
    step();
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    check("sr.rom_addr", 32'(bus.rom_addr), 32'h02);
    check("sr.if_valid", 32'(bus.if_valid), 32'h0);
    check("sr.fetch_cnt", 32'(bus.fetch_cnt), 32'd14);

    // PC wrap from 3F
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 6'h3F;
    step();
    bus.redirect_valid = 1'b0;
    check("wrap.pre_addr", 32'(bus.rom_addr), 32'h3F);
    step();
    check("wrap.rom_addr", 32'(bus.rom_addr), 32'h00);
    check("wrap.if_pc", 32'(bus.if_pc), 32'h3F);
    check("wrap.if_pc_plus1", 32'(bus.if_pc_plus1), 32'h00);
    check("wrap.if_inst", bus.if_inst, 32'h00000000);
    check("wrap.if_valid", 32'(bus.if_valid), 32'h1);

    // Mid-run reset
    step();
    step();
    rst = 1'b1;
    step();
    check_reset("midrst");
    rst = 1'b0;

    // Counter wrap: 65535 accepts from reset, then one more
    repeat (65535) @(posedge clk);
    #1;
    check("cnt.max", 32'(bus.fetch_cnt), 32'h0000FFFF);
    step();
    check("cnt.wrap", 32'(bus.fetch_cnt), 32'h00000000);
    check("cnt.if_valid", 32'(bus.if_valid), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
